store_buffer: RTL
=================

# store_buffer

Posted-write buffer between the datapath store port and the 16-bit data memory `M`. It accepts store requests over a valid/ready handshake and queues them in an in-order FIFO. Queued stores retire into the memory's single write port whenever that port is granted. Loads issued while stores are pending get the youngest buffered value for a matching address; otherwise they receive the memory's read data.

## Interface
- `DEPTH`, 4: buffer entries; power of two, at least 2.
- `ADDR_WIDTH`, 16: address width; matches `M`.
- `DATA_WIDTH`, 16: data width; matches `M`.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `In_Valid`  in  1  store request present.
- `In_Ready`  out  1  buffer can accept a store this cycle.
- `In_Address`  in  ADDR_WIDTH  store address.
- `In_Data`  in  DATA_WIDTH  store data.
- `Drain_Enable`  in  1  memory write port granted this cycle.
- `Write_Enable`  out  1  to `M.Write_Enable`.
- `Write_Address`  out  ADDR_WIDTH  to `M.Write_Address`.
- `Write_Data`  out  DATA_WIDTH  to `M.Write_Data`.
- `Lookup_Address`  in  ADDR_WIDTH  load address.
- `Read_Address`  out  ADDR_WIDTH  to `M.Read_Address`; equals `Lookup_Address`, combinational.
- `Mem_Read_Data`  in  DATA_WIDTH  from `M.Read_Data`.
- `Lookup_Data`  out  DATA_WIDTH  load result.
- `Lookup_Hit`  out  1  load served from the buffer.
- `Count`  out  log2(DEPTH)+1  occupied entries.
- `Empty`  out  1  Count == 0.
- `Full`  out  1  Count == DEPTH.

## Operation
- **Storage:** circular FIFO of {address, data} entries. Head and tail pointers are log2(DEPTH)+1 bits wide; the extra bit is the wrap flag.
  - Full: pointers equal except the wrap bit.
  - Empty: pointers fully equal.
- **Enqueue:** `In_Ready = !Full`, from registered state only; there is no path from `Drain_Enable`. A store is accepted when `In_Valid && In_Ready`; the tail entry is written and the tail advances on that edge. `In_Valid` while Full is ignored and dropped.
- **Drain:**
  - `Write_Enable = Drain_Enable && !Empty`, combinational.
  - When `Write_Enable` is 1, `Write_Address`/`Write_Data` carry the head entry. When it is 0, both are 0.
  - `M` samples the write on the rising edge; the head advances on that same edge.
  - Stores retire strictly in acceptance order, at most one per cycle.
- **Simultaneous enqueue and drain:** both pointers advance and Count is unchanged.
  - Enqueue at Full is impossible even if a drain occurs in the same cycle.
  - Pointer wrap is by natural overflow of the pointer width.
- **Forwarding:**
  - All occupied entries are compared to `Lookup_Address`. The youngest matching entry wins.
  - The head entry being drained this cycle still participates, because memory is not yet updated.
  - The store being accepted this cycle does not participate.
  - On a hit: `Lookup_Hit = 1` and `Lookup_Data` is the entry's data.
  - On a miss: `Lookup_Hit = 0` and `Lookup_Data = Mem_Read_Data`.
  - The whole forwarding path is combinational.
- **Reset (Reset = 0):** asynchronous; all of the following hold while Reset is low:
  - Pointers are 0 and entries are cleared to 0.
  - Count 0, Empty 1, Full 0.
  - In_Ready 0.
  - Write_Enable 0, Write_Address 0, Write_Data 0.
  - Lookup_Hit 0.
  - Any pending stores are discarded, including a store in flight mid-cycle.

## Timing
- Store-to-memory latency: at minimum, a store accepted at edge N is written to `M` at edge N+1, provided `Drain_Enable` is high during the cycle between those edges.
- Forwarding is visible in the cycle after acceptance, and continues until the edge that retires the matching entry.
- `In_Ready` rises in the cycle after the edge at which the buffer leaves Full.
- After Reset deasserts, `In_Ready` is 1 in that same cycle if the buffer is not Full, which it never is after reset.

## Test plan
- **Reset:** assert Reset low mid-operation with Count = 3.
  - Required: immediately Count 0, Empty 1, Write_Enable 0, In_Ready 0.
  - After release, Lookup of a previously buffered address gives Lookup_Hit 0.
- **Fill:** Drain_Enable 0; push addresses 0..3 with data 0xBEEF+i.
  - Required: Count 4, Full 1, In_Ready 0.
  - A fifth push (addr 9, data 0x1234) is dropped; Lookup addr 9 gives Hit 0.
- **Forwarding order:** Drain_Enable 0; push addr 2 with 0x1111, then addr 2 with 0x2222.
  - Required: Lookup addr 2 gives Hit 1, data 0x2222.
  - Lookup addr 7 gives Hit 0, data equal to Mem_Read_Data.
- **Drain into `M`:** from the filled state, hold Drain_Enable 1.
  - Required: Write_Enable high for 4 consecutive cycles with addresses 0,1,2,3 in order; Empty 1 afterwards.
  - Reading `M` addresses 0..3 returns 0xBEEF, 0xBEF0, 0xBEF1, 0xBEF2.
- **Simultaneous push and drain:** at Count 2, push addr 5 with Drain_Enable 1.
  - Required: Count stays 2; the retired address is the oldest entry.
- **Wrap-around:** 10 pushes, with Drain_Enable toggled every other cycle.
  - Required: the memory write sequence exactly matches push order; there are no duplicate or lost writes; Count returns to 0.

Source files
------------

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with in-order drain and load forwarding
module store_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   input  logic [ADDR_WIDTH-1:0]    In_Address,
   input  logic [DATA_WIDTH-1:0]    In_Data,
   input  logic                     Drain_Enable,
   output logic                     Write_Enable,
   output logic [ADDR_WIDTH-1:0]    Write_Address,
   output logic [DATA_WIDTH-1:0]    Write_Data,
   input  logic [ADDR_WIDTH-1:0]    Lookup_Address,
   output logic [ADDR_WIDTH-1:0]    Read_Address,
   input  logic [DATA_WIDTH-1:0]    Mem_Read_Data,
   output logic [DATA_WIDTH-1:0]    Lookup_Data,
   output logic                     Lookup_Hit,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Empty,
   output logic                     Full
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // pointers carry one extra wrap bit so full and empty are distinguishable
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_d [DEPTH];

   logic [PTR_W-1:0]      count_w;
   logic                  empty_w;
   logic                  full_w;
   logic                  push_w;
   logic                  pop_w;
   logic                  hit_w;
   logic [DATA_WIDTH-1:0] fwd_data_w;
   logic [IDX_W-1:0]      scan_idx;

   assign count_w = tail_q - head_q;
   assign empty_w = (head_q == tail_q);
   assign full_w  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                    (head_q[IDX_W] != tail_q[IDX_W]);

   // ready depends only on stored occupancy; held low while reset is asserted
   assign In_Ready = Reset && !full_w;
   assign push_w   = In_Valid && In_Ready;
   assign pop_w    = Drain_Enable && !empty_w;

   assign Write_Enable  = pop_w;
   assign Write_Address = pop_w ? addr_q[head_q[IDX_W-1:0]] : '0;
   assign Write_Data    = pop_w ? data_q[head_q[IDX_W-1:0]] : '0;

   assign Read_Address = Lookup_Address;
   assign Count        = count_w;
   assign Empty        = empty_w;
   assign Full         = full_w;

   // next-state: advance pointers on accept/retire and write the tail entry
   always_comb begin
      head_d = head_q + PTR_W'(pop_w);
      tail_d = tail_q + PTR_W'(push_w);
      for (int i = 0; i < DEPTH; i++) begin
         addr_d[i] = addr_q[i];
         data_d[i] = data_q[i];
      end
      if (push_w) begin
         addr_d[tail_q[IDX_W-1:0]] = In_Address;
         data_d[tail_q[IDX_W-1:0]] = In_Data;
      end
   end

   // state registers; reset discards every queued store
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   // forwarding: scan oldest to youngest so the youngest match wins; the
   // head being drained still counts since memory has not been written yet
   always_comb begin
      hit_w      = 1'b0;
      fwd_data_w = '0;
      scan_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = head_q[IDX_W-1:0] + IDX_W'(k);
         if ((PTR_W'(k) < count_w) && (addr_q[scan_idx] == Lookup_Address)) begin
            hit_w      = 1'b1;
            fwd_data_w = data_q[scan_idx];
         end
      end
   end

   assign Lookup_Hit  = hit_w;
   assign Lookup_Data = hit_w ? fwd_data_w : Mem_Read_Data;

endmodule
